// File: rtl/pipelined_carry_adder.sv
// Pipelined ripple adder: WIDTH-bit A+B+cin split into STAGES carry slices with a valid/ready handshake.
// Optional `ADDER_SUB_MODE_EN adds a per-beat sub input that computes A-B.
module pipelined_carry_adder #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             cin,
`ifdef ADDER_SUB_MODE_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int SLICE = WIDTH / STAGES;
  localparam int L     = STAGES - 1;

  logic                          adv;
  logic [STAGES-1:0]             vld_pipe, c_q, c_i, c_n, v_i;
  logic [STAGES-1:0][WIDTH-1:0]  a_q, b_q, s_q, a_i, b_i, s_i, s_n;
  logic [STAGES-1:0][SLICE:0]    t;
  logic [WIDTH-1:0]              b_eff;
  logic                          c_eff, ovf_q, ovf_n;

`ifdef ADDER_SUB_MODE_EN
  assign b_eff = sub ? ~B : B;
  assign c_eff = sub | cin;
`else
  assign b_eff = B;
  assign c_eff = cin;
`endif

  // Stage k sees the registers of stage k-1; stage 0 sees the input port.
  always_comb begin
    a_i[0] = A;
    b_i[0] = b_eff;
    s_i[0] = '0;
    c_i[0] = c_eff;
    v_i[0] = in_valid;
    for (int k = 1; k < STAGES; k++) begin
      a_i[k] = a_q[k-1];
      b_i[k] = b_q[k-1];
      s_i[k] = s_q[k-1];
      c_i[k] = c_q[k-1];
      v_i[k] = vld_pipe[k-1];
    end
    s_n = s_i;
    t   = '0;
    c_n = '0;
    for (int k = 0; k < STAGES; k++) begin
      t[k] = {1'b0, a_i[k][k*SLICE +: SLICE]} + {1'b0, b_i[k][k*SLICE +: SLICE]}
           + {{SLICE{1'b0}}, c_i[k]};
      s_n[k][k*SLICE +: SLICE] = t[k][SLICE-1:0];
      c_n[k] = t[k][SLICE];
    end
    // b_i already holds the effective operand, so this covers subtraction too
    ovf_n = (a_i[L][WIDTH-1] == b_i[L][WIDTH-1]) && (s_n[L][WIDTH-1] != a_i[L][WIDTH-1]);
  end

  assign adv       = ~vld_pipe[L] | out_ready;
  assign in_ready  = adv;
  assign out_valid = vld_pipe[L];
  assign sum       = s_q[L];
  assign cout      = c_q[L];
  assign ovf       = ovf_q;

  // Data registers load only behind a valid beat so the outputs keep their last result across bubbles.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe <= '0;
      a_q      <= '0;
      b_q      <= '0;
      s_q      <= '0;
      c_q      <= '0;
      ovf_q    <= 1'b0;
    end else if (adv) begin
      vld_pipe <= v_i;
      for (int k = 0; k < STAGES; k++) begin
        if (v_i[k]) begin
          a_q[k] <= a_i[k];
          b_q[k] <= b_i[k];
          s_q[k] <= s_n[k];
          c_q[k] <= c_n[k];
        end
      end
      if (v_i[L]) ovf_q <= ovf_n;
    end
  end

  // Last-stage operands and already-consumed low slices are never read.
  logic unused_ok;
  assign unused_ok = ^{a_q, b_q};

endmodule

// File: tb/tb_pipelined_carry_adder.sv
// Scoreboard bench for pipelined_carry_adder: driver pushes model results, negedge monitor pops and compares.
module tb_pipelined_carry_adder;
  localparam int W = 16;
  localparam int S = 4;

  logic         clk = 1'b0;
  logic         rst, in_valid, in_ready, cin, out_valid, out_ready, cout, ovf;
  logic [W-1:0] A, B, sum;
`ifdef ADDER_SUB_MODE_EN
  logic         sub;
`endif

  always #5 clk = ~clk;

  pipelined_carry_adder #(.WIDTH(W), .STAGES(S)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .cin(cin),
`ifdef ADDER_SUB_MODE_EN
    .sub(sub),
`endif
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf)
  );

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    int           acc;
    bit           lat;
  } exp_t;

  exp_t q[$];
  int   total = 0, bad = 0, cyc = 0, stall_left = 0;
  bit   rnd_ready = 0, lat_chk = 1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference: plain integer arithmetic on the whole operands.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic c, input logic s);
    exp_t   e;
    longint ua = a, ub = b, ur, sr;
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
    longint smax = (longint'(1) << (W-1)) - 1;
    longint smin = -(longint'(1) << (W-1));
    if (s) begin
      ur = ua + (longint'(1) << W) - ub;
      sr = sa - sb;
    end else begin
      ur = ua + ub + longint'(c);
      sr = sa + sb + longint'(c);
    end
    e.sum  = ur[W-1:0];
    e.cout = ur[W];
    e.ovf  = (sr > smax) || (sr < smin);
    e.acc  = 0;
    e.lat  = 0;
    return e;
  endfunction

  task automatic step();
    @(posedge clk); #1;
    if (stall_left > 0) begin
      out_ready = 1'b0;
      stall_left--;
    end else out_ready = rnd_ready ? ($urandom_range(3) != 0) : 1'b1;
  endtask

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic c, input logic s);
    int   n = 0;
    bit   acc = 0;
    exp_t e;
    A = a; B = b; cin = c; in_valid = 1'b1;
`ifdef ADDER_SUB_MODE_EN
    sub = s;
`endif
    while (!acc && n < 200) begin
      @(negedge clk);
      if (in_ready) begin
        acc   = 1;
        e     = model(a, b, c, s);
        e.acc = cyc;
        e.lat = lat_chk;
        q.push_back(e);
      end
      step();
      n++;
    end
    in_valid = 1'b0;
    if (!acc) begin
      total++; bad++;
      $display("FAIL send_timeout: beat not accepted, a=%0h b=%0h", a, b);
    end
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 300) begin
      step();
      n++;
    end
    chk("drain_pending", q.size(), 0);
  endtask

  // Monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (!out_valid) chk("in_ready_idle", in_ready, 1);
        else if (!out_ready) begin
          chk("in_ready_stall", in_ready, 0);
          if (q.size() > 0) begin
            chk("hold_sum", sum, q[0].sum);
            chk("hold_cout", cout, q[0].cout);
          end
        end else if (q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_out: sum=%0h with no beat outstanding", sum);
        end else begin
          e = q.pop_front();
          chk("sum", sum, e.sum);
          chk("cout", cout, e.cout);
          chk("ovf", ovf, e.ovf);
          if (e.lat) chk("latency", cyc - e.acc, S);
        end
      end
    end
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; A = '0; B = '0; cin = 1'b0; out_ready = 1'b1;
`ifdef ADDER_SUB_MODE_EN
    sub = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_sum", sum, 0);
    chk("rst_cout", cout, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_in_ready", in_ready, 1);
    step();

    send(16'h1234, 16'h1111, 1'b0, 1'b0);
    drain();

    send(16'hFFFF, 16'h0000, 1'b1, 1'b0);
    send(16'h7FFF, 16'h0001, 1'b0, 1'b0);
    drain();

    lat_chk = 0;
    for (int i = 1; i <= 6; i++) begin
      if (i == 4) stall_left = 3;
      send(W'(i), W'(i), 1'b0, 1'b0);
    end
    drain();
    lat_chk = 1;

    for (int i = 0; i < 16; i++)
      send(W'($urandom), W'($urandom), 1'($urandom), 1'b0);
    drain();

    // Reset with three beats in flight: none may ever emerge.
    for (int i = 0; i < 3; i++) send(W'(16'h0100 + i), 16'h0011, 1'b0, 1'b0);
    rst = 1'b1;
    q.delete();
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_sum", sum, 0);
    repeat (12) step();

    rnd_ready = 1; lat_chk = 0;
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(2) == 0) step();
      send(W'($urandom), W'($urandom), 1'($urandom), 1'b0);
    end
    drain();
    rnd_ready = 0; lat_chk = 1;

`ifdef ADDER_SUB_MODE_EN
    send(16'h0005, 16'h0007, 1'b0, 1'b1);
    send(16'h8000, 16'h0001, 1'b1, 1'b1);
    for (int i = 0; i < 20; i++)
      send(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
    drain();
`endif

    repeat (4) step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
